hs_sync_fifo: RTL and testbench
===============================

# hs_sync_fifo

Clocked receiver that terminates a four-phase bundled-data channel, such as the `r_o/a_o/d_o` output of `swap_sink2`. It synchronises the request into the `clk` domain, captures each token into a small FIFO, and completes the handshake. Tokens are re-presented on a synchronous valid/ready port. It is the boundary stage between the self-timed datapath and clocked logic.

## Interface
- `N`, default 1: token data width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `SYNC`, default 2: synchroniser flops on `r_i`; must be at least 2.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (`rst`=0 resets).
- `r_i`  in  1  four-phase request from upstream; asynchronous to `clk`.
- `a_i`  out  1  four-phase acknowledge to upstream; registered.
- `d_i`  in  N  bundled data; stable from before `r_i` rises until after `a_i` rises.
- `v_o`  out  1  FIFO non-empty; a token is presented on `d_o`.
- `rdy_o`  in  1  consumer ready; pop when `v_o && rdy_o` at the edge.
- `d_o`  out  N  head-of-FIFO data.
- `cnt_o`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- `r_s` is `r_i` after a `SYNC`-flop chain (all flops reset to 0). Only `r_s` is used by the control logic.
- Handshake FSM, two states:
  - `IDLE`, with `a_i`=0: if `r_s`=1 and not full, write `d_i` into `mem[wp]`, increment `wp`, set `a_i`=1, go to `ACKED`. If full, stay in `IDLE` with `a_i` held 0; the upstream simply stalls.
  - `ACKED`, with `a_i`=1: when `r_s`=0, clear `a_i` and go to `IDLE`. No capture happens in `ACKED`.
- Exactly one token is captured per four-phase cycle. `d_i` is sampled only in the `IDLE`→`ACKED` edge.
- Read side:
  - `d_o` = `mem[rp]` (combinational from registered memory and pointer).
  - `v_o` = (`cnt_o` != 0).
  - A pop increments `rp`.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
- `cnt_o` changes per edge as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur on the same edge.
- Full is `cnt_o`==`DEPTH`. A pop on the same edge as a full condition does not enable a push on that edge; the push happens on the following edge at the earliest.
- Reset, asynchronous on `rst`=0:
  - State=`IDLE`, `a_i`=0, synchroniser=0, `wp`=`rp`=0, `cnt_o`=0, `v_o`=0.
  - All `mem` entries are cleared, so `d_o`=0.
- Reset mid-handshake: `a_i` drops immediately. The upstream must share `rst`. If `r_i` is still high after release, it is treated as a new token (captured again) once synchronised.
- `rdy_o` while `v_o`=0 is ignored; there is no underflow and `rp` holds.

## Timing
- From `r_i` rising to `a_i` rising: `SYNC`+1 rising edges when not full. With `SYNC`=2, `a_i` is high 3 edges after `r_i` rises.
- From `r_i` falling to `a_i` falling: `SYNC`+1 edges.
- Minimum four-phase cycle: 2·(`SYNC`+1) clocks plus upstream delay.
- A token is visible on `v_o`/`d_o` in the same cycle `a_i` rises (write and `a_i` are set on the same edge).
- Pop takes effect at the edge. The next entry (or `v_o`=0) appears after that edge. Throughput is 1 pop per clock.
- When full with `r_s`=1, `a_i` rises on the first edge with `cnt_o`<`DEPTH` evaluated in `IDLE`. That is one edge after the freeing pop.

## Test plan
- Reset: hold `rst`=0 with `r_i`=1. Required: `a_i`=0, `v_o`=0, `cnt_o`=0, `d_o`=0. Release `rst`. Required: `a_i`=1 exactly 3 edges later (`SYNC`=2) and `d_o`=`d_i`.
- Single token, `N`=8: drive `d_i`=8'hA5 and raise `r_i`. Required: `a_i` rises after 3 edges and `v_o`=1 with `d_o`=8'hA5. Drop `r_i`. Required: `a_i` falls after 3 edges. Then pulse `rdy_o`. Required: `v_o`=0 and `cnt_o`=0.
- Fill, `DEPTH`=4, `rdy_o`=0: send 8'h01–8'h04. Required: `cnt_o`=4. Send a 5th token 8'h05. Required: `a_i` stays 0 for 20+ clocks. Pop once. Required: `a_i` rises on the next evaluating edge, and the output order is 01,02,03,04,05.
- Wrap: stream 10 tokens 0..9 with `rdy_o`=1 throughout. Required: they are popped in order, `cnt_o` never exceeds 1, and pointers wrap twice with no loss.
- Simultaneous push/pop: with `cnt_o`=2, align a capture edge with `rdy_o`=1. Required: `cnt_o` stays 2 across that edge and the head advances by one.
- Reset mid-handshake: assert `rst` while `a_i`=1 and `cnt_o`=3. Required: `a_i`=0, `cnt_o`=0, and `v_o`=0 asynchronously. After release with `r_i`=0, no spurious capture.

Source files
------------

// File: rtl/hs_sync_fifo.sv
// Clocked receiver for a four-phase bundled-data channel. It synchronises the request,
// captures each token into a small FIFO, and re-presents the tokens on a valid/ready port.
module hs_sync_fifo #(
  parameter int N     = 1,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         r_i,
  output logic                         a_i,
  input  logic [N-1:0]                 d_i,
  output logic                         v_o,
  input  logic                         rdy_o,
  output logic [N-1:0]                 d_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SYNC-1:0] sync_q;
  logic            r_s;
  logic [N-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, push, pop;

  // Request synchroniser; only its last stage feeds the control logic.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q[gi] <= 1'b0;
        end else if (gi == 0) begin
          sync_q[gi] <= r_i;
        end else begin
          sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign r_s  = sync_q[SYNC-1];
  assign full = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (r_s && !full) state_d = ACKED;
      ACKED:   if (!r_s)         state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // A pop on a full edge frees a slot only for the following edge, since full is registered.
  always_comb begin
    a_i  = (state_q == ACKED);
    push = (state_q == IDLE) && r_s && !full;
  end

  assign pop   = v_o && rdy_o;
  assign v_o   = (cnt_q != '0);
  assign cnt_o = cnt_q;
  assign d_o   = mem_q[rp_q];

  always_comb begin
    wp_d  = push ? wp_q + PW'(1) : wp_q;
    rp_d  = pop  ? rp_q + PW'(1) : rp_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wp_q] <= d_i;
    end
  end

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Self-checking bench for hs_sync_fifo: directed handshake/boundary scenarios plus a
// randomized phase, all checked by a queue-based scoreboard sampled on the falling edge.
module tb_hs_sync_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          r_i;
  logic          a_i;
  logic [N-1:0]  d_i;
  logic          v_o;
  logic          rdy_o;
  logic [N-1:0]  d_o;
  logic [CW-1:0] cnt_o;

  logic rdy_rand, rdy_r, rdy_dir;
  bit   wrap_chk;
  int   n_cmp, n_err;

  logic [N-1:0] sb[$];
  logic         a_prev;

  assign rdy_o = rdy_rand ? rdy_r : rdy_dir;

  hs_sync_fifo #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk   (clk),
    .rst   (rst),
    .r_i   (r_i),
    .a_i   (a_i),
    .d_i   (d_i),
    .v_o   (v_o),
    .rdy_o (rdy_o),
    .d_o   (d_o),
    .cnt_o (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rdy_r = 1'($urandom_range(0, 1));
  end

  // Scoreboard: a token enters the expected queue on the cycle its acknowledge appears,
  // and leaves it when a pop is presented to the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      a_prev = 1'b0;
    end else begin
      if (a_i && !a_prev) sb.push_back(d_i);
      a_prev = a_i;
      chk("cnt", 32'(cnt_o), 32'(sb.size()));
      chk("valid", 32'(v_o), 32'(sb.size() != 0));
      if (wrap_chk) chk("wrap_cnt_le1", 32'(cnt_o <= 1), 32'd1);
      if (sb.size() != 0) begin
        chk("head", 32'(d_o), 32'(sb[0]));
        if (rdy_o) void'(sb.pop_front());
      end
    end
  end

  task automatic wait_a(input logic lvl, input int max, output int e);
    e = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end while (a_i !== lvl && e < max);
    if (a_i !== lvl) chk("ack_timeout", 32'(a_i), 32'(lvl));
  endtask

  task automatic send(input logic [N-1:0] tok, input bit chk_lat);
    int e;
    @(posedge clk); #1;
    d_i = tok;
    r_i = 1'b1;
    wait_a(1'b1, 200, e);
    if (chk_lat) chk("rise_latency", 32'(e), 32'(SYNC+1));
    r_i = 1'b0;
    wait_a(1'b0, 200, e);
    if (chk_lat) chk("fall_latency", 32'(e), 32'(SYNC+1));
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cnt_o != 0 && k < 50);
    chk("drain_empty", 32'(cnt_o), 32'd0);
    @(posedge clk); #1;
    rdy_dir = 1'b0;
  endtask

  initial begin
    int e;
    n_cmp = 0; n_err = 0;
    rdy_rand = 1'b0; rdy_dir = 1'b0; wrap_chk = 1'b0;
    rst = 1'b0; r_i = 1'b1; d_i = 8'h3C;

    // Reset held with request high
    repeat (4) @(negedge clk);
    chk("rst_ack", 32'(a_i), 32'd0);
    chk("rst_valid", 32'(v_o), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_dout", 32'(d_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_a(1'b1, 50, e);
    chk("post_rst_latency", 32'(e), 32'(SYNC+1));
    chk("post_rst_dout", 32'(d_o), 32'h3C);
    r_i = 1'b0;
    wait_a(1'b0, 50, e);
    drain();

    // Single token
    send(8'hA5, 1'b1);
    @(negedge clk);
    chk("single_valid", 32'(v_o), 32'd1);
    chk("single_dout", 32'(d_o), 32'hA5);
    @(posedge clk); #1; rdy_dir = 1'b1;
    @(posedge clk); #1; rdy_dir = 1'b0;
    @(negedge clk);
    chk("single_popped_valid", 32'(v_o), 32'd0);
    chk("single_popped_cnt", 32'(cnt_o), 32'd0);

    // Fill, then stall a fifth token until one pop frees a slot
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    @(negedge clk);
    chk("full_cnt", 32'(cnt_o), 32'd4);
    @(posedge clk); #1;
    d_i = 8'h05; r_i = 1'b1;
    repeat (22) begin
      @(negedge clk);
      chk("full_stall_ack", 32'(a_i), 32'd0);
    end
    @(posedge clk); #1; rdy_dir = 1'b1;
    @(posedge clk); #1; rdy_dir = 1'b0;
    @(negedge clk);
    chk("pop_edge_no_push_ack", 32'(a_i), 32'd0);
    chk("pop_edge_cnt", 32'(cnt_o), 32'd3);
    @(negedge clk);
    chk("next_edge_ack", 32'(a_i), 32'd1);
    chk("next_edge_cnt", 32'(cnt_o), 32'd4);
    r_i = 1'b0;
    wait_a(1'b0, 50, e);
    drain();

    // Wrap with consumer always ready
    rdy_dir = 1'b1;
    wrap_chk = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b1);
    wrap_chk = 1'b0;
    drain();

    // Push and pop on the same edge
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    @(posedge clk); #1;
    d_i = 8'h33; r_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    @(negedge clk);
    chk("simul_pre_cnt", 32'(cnt_o), 32'd2);
    chk("simul_pre_head", 32'(d_o), 32'h11);
    @(posedge clk); #1;
    rdy_dir = 1'b0;
    @(negedge clk);
    chk("simul_ack", 32'(a_i), 32'd1);
    chk("simul_cnt", 32'(cnt_o), 32'd2);
    chk("simul_head", 32'(d_o), 32'h22);
    r_i = 1'b0;
    wait_a(1'b0, 50, e);
    drain();

    // Randomized traffic
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(8'($urandom), 1'b0);
    end
    rdy_rand = 1'b0;
    drain();

    // Reset in the middle of a handshake
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    @(posedge clk); #1;
    d_i = 8'h73; r_i = 1'b1;
    wait_a(1'b1, 50, e);
    chk("mid_pre_cnt", 32'(cnt_o), 32'd3);
    @(posedge clk); #3;
    rst = 1'b0; r_i = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(a_i), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_o), 32'd0);
    chk("mid_rst_valid", 32'(v_o), 32'd0);
    chk("mid_rst_dout", 32'(d_o), 32'd0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_spurious_ack", 32'(a_i), 32'd0);
      chk("no_spurious_cnt", 32'(cnt_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
